// File: rtl/chacha_core_iter.sv
// ===========================================================================
//  Module      : chacha_core_iter
//  Description : Iterative ChaCha block function, one quarter-round step per
//                clock, with optional feed-forward add of the input state.
//  Revision    : 1.0 - initial release
// ===========================================================================
`default_nettype none

module chacha_core_iter #(
  parameter int ROUNDS    = 20,
  parameter int FINAL_ADD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state,
  output logic         busy
);

  if ((ROUNDS < 2) || (ROUNDS > 30) || ((ROUNDS % 2) != 0)) begin : g_rounds_check
    $error("chacha_core_iter: ROUNDS must be even and within 2..30");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  state_t              state_q, state_d;
  logic [1:0]          step_q, step_d;
  logic [1:0]          qr_q, qr_d;
  logic [4:0]          round_q, round_d;
  logic [15:0][31:0]   work_q, work_d;
  logic [15:0][31:0]   orig_q, orig_d;
  logic [511:0]        out_q, out_d;

  logic [1:0]          qr_p1, qr_p2, qr_p3;
  logic [3:0]          idx_a, idx_b, idx_c, idx_d;
  logic [3:0]          idx_p, idx_m, idx_t;
  logic [31:0]         step_sum, step_mix, step_rot;
  logic [15:0][31:0]   step_work;

  // Word selection: diagonal rounds shift b/c/d columns by 1/2/3 positions.
  always_comb begin
    qr_p1 = qr_q + 2'd1;
    qr_p2 = qr_q + 2'd2;
    qr_p3 = qr_q + 2'd3;
    idx_a = {2'd0, qr_q};
    if (round_q[0]) begin
      idx_b = {2'd1, qr_p1};
      idx_c = {2'd2, qr_p2};
      idx_d = {2'd3, qr_p3};
    end else begin
      idx_b = {2'd1, qr_q};
      idx_c = {2'd2, qr_q};
      idx_d = {2'd3, qr_q};
    end
    // Even steps: a+=b, d^=a. Odd steps: c+=d, b^=c.
    idx_p = step_q[0] ? idx_c : idx_a;
    idx_m = step_q[0] ? idx_d : idx_b;
    idx_t = step_q[0] ? idx_b : idx_d;

    step_sum = work_q[idx_p] + work_q[idx_m];
    step_mix = work_q[idx_t] ^ step_sum;
    case (step_q)
      2'd0:    step_rot = {step_mix[15:0], step_mix[31:16]};
      2'd1:    step_rot = {step_mix[19:0], step_mix[31:20]};
      2'd2:    step_rot = {step_mix[23:0], step_mix[31:24]};
      default: step_rot = {step_mix[24:0], step_mix[31:25]};
    endcase

    step_work        = work_q;
    step_work[idx_p] = step_sum;
    step_work[idx_t] = step_rot;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    qr_d    = qr_q;
    round_d = round_q;
    work_d  = work_q;
    orig_d  = orig_q;
    out_d   = out_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          orig_d  = in_state;
          step_d  = 2'd0;
          qr_d    = 2'd0;
          round_d = 5'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        work_d = step_work;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          qr_d = qr_q + 2'd1;
          if (qr_q == 2'd3) begin
            if (round_q == LAST_ROUND) begin
              round_d = 5'd0;
              if (FINAL_ADD != 0) begin
                state_d = S_ADD;
              end else begin
                out_d   = step_work;
                state_d = S_DONE;
              end
            end else begin
              round_d = round_q + 5'd1;
            end
          end
        end
      end
      S_ADD: begin
        for (int i = 0; i < 16; i++) begin
          out_d[32*i +: 32] = work_q[i] + orig_q[i];
        end
        state_d = S_DONE;
      end
      default: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      qr_q    <= 2'd0;
      round_q <= 5'd0;
      work_q  <= '0;
      orig_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      qr_q    <= qr_d;
      round_q <= round_d;
      work_q  <= work_d;
      orig_q  <= orig_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign out_state = out_q;

endmodule

`default_nettype wire

// File: tb/tb_chacha_core_iter.sv
// ===========================================================================
//  Module      : tb_chacha_core_iter
//  Description : Directed self-checking bench for chacha_core_iter
//                (ChaCha20 with feed-forward, ChaCha8 raw permutation).
//  Revision    : 1.0 - initial release
// ===========================================================================
`default_nettype none

module tb_chacha_core_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv20, ir20, ov20, or20, busy20;
  logic [511:0] is20, os20;
  logic         iv8, ir8, ov8, or8, busy8;
  logic [511:0] is8, os8;

  int total = 0;
  int bad   = 0;

  logic [511:0] rfc_in, rfc_out;

  always #5 clk = ~clk;

  chacha_core_iter #(.ROUNDS(20), .FINAL_ADD(1)) dut20 (
    .clk(clk), .rst(rst),
    .in_valid(iv20), .in_ready(ir20), .in_state(is20),
    .out_valid(ov20), .out_ready(or20), .out_state(os20), .busy(busy20)
  );

  chacha_core_iter #(.ROUNDS(8), .FINAL_ADD(0)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .in_state(is8),
    .out_valid(ov8), .out_ready(or8), .out_state(os8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic send20(input logic [511:0] st);
    int k = 0;
    while (!ir20 && k < 50) begin tick(); k++; end
    chk("accept_ready20", ir20, 1'b1);
    iv20 = 1'b1;
    is20 = st;
    tick();
    iv20 = 1'b0;
  endtask

  task automatic wait20(input bit perturb, output int n);
    n = 0;
    while (!ov20 && n < 1000) begin
      if (perturb) begin
        iv20 = 1'($urandom);
        is20 = rnd512();
      end
      tick();
      n++;
    end
    iv20 = 1'b0;
  endtask

  task automatic release20();
    or20 = 1'b1;
    tick();
    or20 = 1'b0;
  endtask

  initial begin
    int   n;
    bit   changed, rdy_seen, ov_lost, seen;
    logic [511:0] snap;

    rfc_in  = {32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
               32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
               32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
               32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    rfc_out = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
               32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
               32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
               32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

    rst = 1'b1;
    iv20 = 1'b1; is20 = rfc_in; or20 = 1'b0;
    iv8  = 1'b1; is8  = '0;     or8  = 1'b0;

    // Reset held for two cycles with in_valid asserted
    tick();
    tick();
    chk("rst_in_ready",  ir20,   1'b0);
    chk("rst_out_valid", ov20,   1'b0);
    chk("rst_busy",      busy20, 1'b0);
    chk("rst_out_state", os20,   512'h0);
    chk("rst_in_ready8", ir8,    1'b0);
    iv20 = 1'b0; iv8 = 1'b0;
    rst  = 1'b0;
    #1;
    chk("post_rst_ready", ir20, 1'b1);

    // RFC 7539 block, latency and contents
    send20(rfc_in);
    chk("busy_run", busy20, 1'b1);
    chk("ready_run", ir20, 1'b0);
    wait20(1'b0, n);
    chk("lat20", 32'(n), 32'd321);
    chk("rfc_w0",  os20[31:0],    32'he4e7f110);
    chk("rfc_w1",  os20[63:32],   32'h15593bd1);
    chk("rfc_w15", os20[511:480], 32'h4e3c50a2);
    chk("rfc_full", os20, rfc_out);

    // Backpressure with a competing request
    snap = os20; changed = 0; rdy_seen = 0; ov_lost = 0;
    for (int i = 0; i < 50; i++) begin
      iv20 = 1'b1;
      is20 = rnd512();
      tick();
      if (os20 !== snap) changed = 1;
      if (ir20) rdy_seen = 1;
      if (!ov20) ov_lost = 1;
    end
    chk("bp_changed",  changed,  1'b0);
    chk("bp_in_ready", rdy_seen, 1'b0);
    chk("bp_ov_lost",  ov_lost,  1'b0);
    chk("bp_hold", os20, rfc_out);

    // Release, then back-to-back second block
    or20 = 1'b1; iv20 = 1'b1; is20 = rfc_in;
    tick();
    chk("rel_out_valid", ov20, 1'b0);
    chk("rel_in_ready",  ir20, 1'b1);
    chk("idle_keeps_out", os20, rfc_out);
    tick();
    iv20 = 1'b0; or20 = 1'b0;
    chk("b2b_busy", busy20, 1'b1);
    wait20(1'b0, n);
    chk("b2b_lat", 32'(n), 32'd321);
    chk("b2b_full", os20, rfc_out);
    release20();

    // Reset around cycle 100 of a block
    send20(rfc_in);
    for (int i = 0; i < 99; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy20, 1'b0);
    chk("mid_rst_out",  os20, 512'h0);
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (ov20) seen = 1;
    end
    chk("mid_rst_no_ov", seen, 1'b0);
    send20(rfc_in);
    wait20(1'b0, n);
    chk("after_rst_lat", 32'(n), 32'd321);
    chk("after_rst_full", os20, rfc_out);
    release20();

    // Input noise during RUN must not matter
    send20(rfc_in);
    wait20(1'b1, n);
    chk("perturb_lat", 32'(n), 32'd321);
    chk("perturb_full", os20, rfc_out);
    release20();

    // ChaCha8 on all-zero state, no feed-forward
    n = 0;
    while (!ir8 && n < 50) begin tick(); n++; end
    chk("accept_ready8", ir8, 1'b1);
    iv8 = 1'b1; is8 = '0;
    tick();
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 1000) begin tick(); n++; end
    chk("lat8", 32'(n), 32'd128);
    chk("zero8", os8, 512'h0);
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    chk("rel8_out_valid", ov8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
